piso_register: RTL and testbench
================================

# piso_register

Parallel-in/serial-out register: accepts an N-bit word over a valid/ready load handshake and emits it one bit per accepted transfer on a serial valid/ready stream, MSB first. It is the unload end of the parallel word registers in the datapath: a word captured in parallel leaves through this block as a bit stream. It supports back-to-back words with no idle cycle and downstream stalls at any bit.

## Interface
- N, default 5: word width in bits; legal range N >= 2.
- CW, default $clog2(N): bit-counter width; derived, not overridden.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk externally.
- load_valid  input  1  D holds a word to serialize.
- load_ready  output  1  block can accept a word this cycle.
- D  input  N  parallel word; sampled only on load handshake.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout is valid.
- sout_ready  input  1  downstream accepts sout this cycle.
- sout_last  output  1  sout carries bit 0 (final bit) of the word.
- busy  output  1  a word is loaded and not fully transferred.

## Operation
- State: IDLE, SHIFT. Registers: sreg[N-1:0], cnt[CW-1:0], state.
- Load handshake: load_fire = load_valid & load_ready. Serial handshake: bit_fire = sout_valid & sout_ready.
- load_ready = (state==IDLE) | (state==SHIFT & cnt==N-1 & sout_ready); combinational from state, cnt, sout_ready.
- IDLE: sout_valid=0, busy=0. On load_fire: sreg<=D, cnt<=0, state<=SHIFT.
- SHIFT: sout_valid=1, busy=1, sout=sreg[N-1], sout_last=(cnt==N-1).
  - bit_fire and cnt<N-1: sreg<=sreg<<1 (zero fill), cnt<=cnt+1.
  - bit_fire and cnt==N-1 and load_fire: sreg<=D, cnt<=0, stay SHIFT (gapless).
  - bit_fire and cnt==N-1, no load_fire: state<=IDLE, cnt<=0.
  - no bit_fire: sreg, cnt, state hold; sout stable (stall).
- load_valid in SHIFT before the last bit: ignored, D not sampled (load_ready=0).
- sout, sout_last forced 0 when sout_valid=0.
- Reset (rst_n low, any time, including mid-word): state=IDLE, sreg=0, cnt=0 immediately; in-flight word discarded, no partial completion. Outputs during and after reset: sout=0, sout_valid=0, sout_last=0, busy=0, load_ready=1 (loads are not captured while rst_n low).

## Timing
- Load-to-first-bit latency: 1 cycle (word accepted at edge k, bit N-1 on sout in cycle after edge k).
- Unstalled word duration: N cycles of sout_valid; sout_last high in Nth.
- Throughput: 1 bit/cycle sustained across words when load_valid is held high and sout_ready=1; zero bubble between words.
- Stall: sout_ready low for S cycles extends the word by S cycles; sout/sout_last hold unchanged.
- cnt never exceeds N-1; no wrap beyond word length.

## Test plan
- Reset: rst_n=0 then release -> sout_valid=0, busy=0, sout=0, load_ready=1; rst_n=0 for one cycle mid-word resets to IDLE with sout_valid=0 the same cycle.
- Single word, N=5, D=5'b10110, sout_ready=1 -> sout 1,0,1,1,0 over 5 cycles starting 1 cycle after load; sout_last only on 5th; then IDLE, load_ready=1.
- Back-to-back: D=5'b11001 then 5'b00111, load_valid held -> 10 contiguous valid bits 1,1,0,0,1,0,0,1,1,1; second load accepted in the sout_last cycle; sout_last on bits 5 and 10.
- Stall: D=5'b10101, sout_ready low for 3 cycles at bit index 2 -> sout holds 1 for 3 extra cycles, total 8 valid cycles, stream still 1,0,1,0,1.
- Load ignored while busy: new D=5'b11111 asserted during bits 1-3 of 5'b00000 -> load_ready=0, stream 0,0,0,0,0 intact; 5'b11111 accepted in sout_last cycle.
- Last-bit stall: sout_ready=0 during sout_last with load_valid=1 -> load_ready=0, no capture until sout_ready=1.

Source files
------------

// File: rtl/piso_register.sv
// Parallel-in/serial-out register: takes an N-bit word on a load handshake and
// streams it out MSB first on a valid/ready serial port, gapless across words.
//
//   state   | meaning
//   S_IDLE  | no word held; load_ready high, serial output idle
//   S_SHIFT | word in flight; sout = sreg_q[N-1], cnt_q = index of bit being sent
module piso_register #(
   parameter  int unsigned N  = 5,
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [N-1:0] D,
   output logic         sout,
   output logic         sout_valid,
   input  logic         sout_ready,
   output logic         sout_last,
   output logic         busy
);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t        state_q, state_d;
   logic [N-1:0]  sreg_q, sreg_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          load_fire, bit_fire;

   assign load_fire = load_valid & load_ready;
   assign bit_fire  = sout_valid & sout_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (load_fire) begin
               sreg_d  = D;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (bit_fire) begin
               if (cnt_q != LAST) begin
                  sreg_d = {sreg_q[N-2:0], 1'b0};
                  cnt_d  = cnt_q + CW'(1);
               end else if (load_fire) begin
                  // next word replaces the last bit on the same edge: no bubble
                  sreg_d = D;
                  cnt_d  = '0;
               end else begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      load_ready = 1'b1;
      sout_valid = 1'b0;
      sout       = 1'b0;
      sout_last  = 1'b0;
      busy       = 1'b0;
      if (state_q == S_SHIFT) begin
         load_ready = (cnt_q == LAST) & sout_ready;
         sout_valid = 1'b1;
         sout       = sreg_q[N-1];
         sout_last  = (cnt_q == LAST);
         busy       = 1'b1;
      end
   end

endmodule

// File: tb/tb_piso_register.sv
// Scoreboard bench for piso_register: the driver models the word in flight as a
// count of remaining bits and queues expected bits; the monitor checks the stream.
module tb_piso_register;

   localparam int N = 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         load_valid = 1'b0;
   logic         load_ready;
   logic [N-1:0] D = '0;
   logic         sout;
   logic         sout_valid;
   logic         sout_ready = 1'b0;
   logic         sout_last;
   logic         busy;

   int checks = 0;
   int failures = 0;

   // expected stream entries: {bit, last}
   logic [1:0] exp_q[$];
   int         remaining = 0;
   logic       exp_valid = 1'b0;
   logic       exp_ready = 1'b1;
   bit         run = 1'b1;

   piso_register #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .D          (D),
      .sout       (sout),
      .sout_valid (sout_valid),
      .sout_ready (sout_ready),
      .sout_last  (sout_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0b required=%0b", name, $time, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (run) begin
         logic [1:0] e;
         chk("sout_valid", sout_valid, exp_valid);
         chk("busy", busy, exp_valid);
         chk("load_ready", load_ready, exp_ready);
         if (!sout_valid) begin
            chk("sout_idle_zero", sout, 1'b0);
            chk("sout_last_idle_zero", sout_last, 1'b0);
         end else if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_bit t=%0t actual=sout_valid required=no_word", $time);
         end else begin
            e = exp_q[0];
            chk("sout_bit", sout, e[1]);
            chk("sout_last", sout_last, e[0]);
            if (sout_ready) void'(exp_q.pop_front());
         end
      end
   end

   // One clock cycle of stimulus; the model advances by the rules of the block.
   task automatic drive(input logic lv, input logic [N-1:0] d, input logic sr);
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      load_valid = lv;
      D          = d;
      sout_ready = sr;
      exp_valid  = (remaining > 0);
      exp_ready  = (remaining == 0) || (remaining == 1 && sr);
      if (remaining > 0 && sr) remaining--;
      if (lv && exp_ready) begin
         remaining = N;
         for (int i = N - 1; i >= 0; i--) exp_q.push_back({d[i], (i == 0) ? 1'b1 : 1'b0});
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n      = 1'b0;
      load_valid = 1'b1;
      D          = N'($urandom);
      sout_ready = 1'b1;
      remaining  = 0;
      exp_q.delete();
      exp_valid  = 1'b0;
      exp_ready  = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1);
   endtask

   initial begin
      repeat (3) @(posedge clk);

      // single word
      drive(1'b1, 5'b10110, 1'b1);
      idle(7);

      // back-to-back with load_valid held
      drive(1'b1, 5'b11001, 1'b1);
      repeat (5) drive(1'b1, 5'b00111, 1'b1);
      idle(7);

      // stall for 3 cycles at bit index 2
      drive(1'b1, 5'b10101, 1'b1);
      repeat (2) drive(1'b0, '0, 1'b1);
      repeat (3) drive(1'b0, '0, 1'b0);
      idle(7);

      // load offered while busy is ignored until the last bit
      drive(1'b1, 5'b00000, 1'b1);
      repeat (5) drive(1'b1, 5'b11111, 1'b1);
      idle(7);

      // stall on the last bit with a pending load
      drive(1'b1, 5'b01101, 1'b1);
      repeat (3) drive(1'b0, '0, 1'b1);
      drive(1'b1, 5'b10011, 1'b1);
      repeat (2) drive(1'b1, 5'b10011, 1'b0);
      drive(1'b1, 5'b10011, 1'b1);
      idle(7);

      // reset mid-word
      drive(1'b1, 5'b11111, 1'b1);
      drive(1'b0, '0, 1'b1);
      do_reset();
      idle(4);

      // randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         else drive(1'($urandom_range(0, 3) != 0), N'($urandom), 1'($urandom_range(0, 3) != 0));
      end
      idle(2 * N + 4);

      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d_bits_pending required=0", exp_q.size());
      end
      run = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
